add_round_key_ks: RTL and testbench

- Registered AddRoundKey stage with an on-the-fly AES-128 key schedule.
- Sits directly downstream of the MixColumns stage in the round datapath. Each accepted 128-bit state is XORed with the current round key, and the schedule then advances to the next round key.
- The block holds the cipher key and replays rounds 0..10 per block, so the round controller only has to drive the handshake.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_sbox.sv | 44 ++++
 rtl/add_round_key_ks.sv | 128 ++++++++++++
 tb/tb_add_round_key_ks.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the round datapath.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  GF_POLY   = 8'h1B;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[x];

endmodule

// File: rtl/add_round_key_ks.sv
// Registered AddRoundKey stage with an on-the-fly AES-128 key schedule.
// Define AES_RK_DEBUG_EN to expose the round key used for out_state on rk_dbg.
module add_round_key_ks
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [KEY_W-1:0] cipher_key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_state,
    output logic [3:0]       out_round,
    output logic             out_last
`ifdef AES_RK_DEBUG_EN
    ,
    output logic [KEY_W-1:0] rk_dbg
`endif
);

    localparam logic [3:0] LastRound = 4'(NR);

    aes_state_t cipher_key_q;
    aes_state_t round_key_q;
    logic [7:0] rcon_q;
    logic [3:0] round_q;
    logic       key_valid_q;

    aes_state_t out_state_q;
    logic [3:0] out_round_q;
    logic       out_last_q;
    logic       out_valid_q;

    logic       accept;
    logic       at_last;
    aes_state_t next_key;

    aes_word_t w0, w1, w2, w3;
    aes_word_t rot_w3, sub_w3, t_word;
    aes_word_t n0, n1, n2, n3;

    assign in_ready = key_valid_q & ~key_load & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign at_last  = (round_q == LastRound);

    assign {w0, w1, w2, w3} = round_key_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .x (rot_w3[8*i +: 8]),
            .y (sub_w3[8*i +: 8])
        );
    end

    always_comb begin
        t_word   = sub_w3 ^ {rcon_q, 24'h000000};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cipher_key_q <= '0;
            round_key_q  <= '0;
            rcon_q       <= RCON_INIT;
            round_q      <= '0;
            key_valid_q  <= 1'b0;
            out_state_q  <= '0;
            out_round_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else if (key_load) begin
            // A key load restarts the schedule and drops any result still held.
            cipher_key_q <= cipher_key;
            round_key_q  <= cipher_key;
            rcon_q       <= RCON_INIT;
            round_q      <= '0;
            key_valid_q  <= 1'b1;
            out_valid_q  <= 1'b0;
        end else if (accept) begin
            out_state_q <= in_state ^ round_key_q;
            out_round_q <= round_q;
            out_last_q  <= at_last;
            out_valid_q <= 1'b1;
            if (at_last) begin
                round_key_q <= cipher_key_q;
                rcon_q      <= RCON_INIT;
                round_q     <= '0;
            end else begin
                round_key_q <= next_key;
                rcon_q      <= xtime(rcon_q);
                round_q     <= round_q + 4'd1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef AES_RK_DEBUG_EN
    aes_state_t rk_dbg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_dbg_q <= '0;
        end else if (!key_load && accept) begin
            rk_dbg_q <= round_key_q;
        end
    end

    assign rk_dbg = rk_dbg_q;
`endif

    assign out_state = out_state_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_round_key_ks.sv
// Scoreboard bench for add_round_key_ks against a FIPS-197 key-expansion model.
module tb_add_round_key_ks;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] cipher_key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
`ifdef AES_RK_DEBUG_EN
    logic [127:0] rk_dbg;
`endif

    always #5 clk = ~clk;

    add_round_key_ks dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .cipher_key (cipher_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .out_round  (out_round),
        .out_last   (out_last)
`ifdef AES_RK_DEBUG_EN
        ,
        .rk_dbg     (rk_dbg)
`endif
    );

    typedef struct packed {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
        logic [127:0] key;
    } exp_t;

    exp_t         sbq[$];
    int           total = 0;
    int           bad = 0;
    logic [7:0]   sb [256];
    logic [127:0] mrk [11];
    int           mr = 0;
    bit           mkv = 0;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FipsRk1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FipsIn = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FipsOut = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One clock of stimulus; the expected result of an accept is queued on the way.
    task automatic step(input bit r, input bit kl, input bit iv, input logic [127:0] is,
                        input bit ordy, input bit use_c, input logic [127:0] cval);
        exp_t e;
        rst = r;
        key_load = kl;
        in_valid = iv;
        in_state = is;
        out_ready = ordy;
        @(negedge clk);
        #1;
        if (r) begin
            sbq.delete();
            mkv = 0;
            mr = 0;
        end else if (kl) begin
            check("ready_at_load", 128'(in_ready), 128'd0);
            sbq.delete();
            expand(cipher_key);
            mkv = 1;
            mr = 0;
        end else if (!mkv) begin
            check("ready_no_key", 128'(in_ready), 128'd0);
        end else if (iv && in_ready) begin
            e.st = use_c ? cval : (is ^ mrk[mr]);
            e.rnd = 4'(mr);
            e.last = (mr == 10);
            e.key = mrk[mr];
            sbq.push_back(e);
            mr = (mr + 1) % 11;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        key_load = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops on every transfer and checks stability while stalled.
    bit           hold_v = 0;
    logic [127:0] hold_s;
    logic [3:0]   hold_r;
    always @(negedge clk) begin
        exp_t e;
        if (hold_v && out_valid) begin
            check("hold_state", out_state, hold_s);
            check("hold_round", 128'(out_round), 128'(hold_r));
        end
        hold_v = out_valid && !out_ready;
        hold_s = out_state;
        hold_r = out_round;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h expected none", out_state);
            end else begin
                e = sbq.pop_front();
                check("out_state", out_state, e.st);
                check("out_round", 128'(out_round), 128'(e.rnd));
                check("out_last", 128'(out_last), 128'(e.last));
`ifdef AES_RK_DEBUG_EN
                check("rk_dbg", rk_dbg, e.key);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        key_load = 1'b0;
        cipher_key = '0;
        in_valid = 1'b0;
        in_state = '0;
        out_ready = 1'b0;
        build_sbox();
        step(1, 0, 0, '0, 0, 0, '0);
        step(1, 0, 0, '0, 0, 0, '0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_out_round", 128'(out_round), 128'd0);
        check("rst_out_last", 128'(out_last), 128'd0);
        step(0, 0, 1, rnd128(), 1, 0, '0);

        // FIPS-197 App. A schedule, then wrap-around with the App. B input.
        cipher_key = FipsKey;
        step(0, 1, 0, '0, 1, 0, '0);
        for (int r = 0; r <= 10; r++)
            step(0, 0, 1, '0, 1, (r == 0 || r == 1 || r == 10),
                 (r == 0) ? FipsKey : ((r == 1) ? FipsRk1 : FipsRk10));
        step(0, 0, 1, FipsIn, 1, 1, FipsOut);
        step(0, 0, 1, rnd128(), 1, 0, '0);

        // Backpressure with a result pending.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, rnd128(), 0, 0, '0);
            check("bp_ready", 128'(in_ready), 128'd0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, rnd128(), 1, 0, '0);

        // key_load collision with a held result and a valid input.
        step(0, 0, 1, rnd128(), 0, 0, '0);
        cipher_key = rnd128();
        step(0, 1, 1, rnd128(), 0, 0, '0);
        check("load_out_valid", 128'(out_valid), 128'd0);
        step(0, 0, 1, '0, 1, 1, cipher_key);
        step(0, 0, 1, rnd128(), 1, 0, '0);

        // Reset mid-block at round 5.
        cipher_key = FipsKey;
        step(0, 1, 0, '0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, rnd128(), 1, 0, '0);
        step(0, 0, 0, '0, 0, 0, '0);
        step(1, 0, 1, rnd128(), 0, 0, '0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd0);
        check("mid_rst_out_state", out_state, 128'd0);
        check("mid_rst_out_round", 128'(out_round), 128'd0);
        step(0, 0, 1, rnd128(), 1, 0, '0);
        step(0, 1, 0, '0, 1, 0, '0);
        step(0, 0, 1, FipsIn, 1, 1, FipsOut);

        // Random traffic across several keys with an occasional mid-stream reload.
        for (int k = 0; k < 3; k++) begin
            cipher_key = rnd128();
            step(0, 1, 0, '0, 0, 0, '0);
            for (int c = 0; c < 60; c++) begin
                if (c == 30 && k == 1) begin
                    cipher_key = rnd128();
                    step(0, 1, ($urandom % 2) == 1, rnd128(), 0, 0, '0);
                end else begin
                    step(0, 0, ($urandom % 4) != 0, rnd128(), ($urandom % 3) != 0, 0, '0);
                end
            end
        end

        for (int i = 0; i < 20 && sbq.size() > 0; i++) step(0, 0, 0, '0, 1, 0, '0);
        check("drain_empty", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
